// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared MEM-stage state encoding and MEM/WB bundle types
package mem_wb_stage_pkg;

   localparam int RD_W   = 5;
   localparam int DATA_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic              regwr;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] wrdata;
   } memwb_t;

   localparam memwb_t MEMWB_BUBBLE = '0;

   // Word accesses only: the two byte-offset bits must be zero.
   function automatic logic word_aligned(input logic [1:0] byte_lsb);
      return (byte_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory request/acknowledge port
interface mem_wb_stage_if
   import mem_wb_stage_pkg::*;
#(
   parameter int AW = 10
);

   logic              mem_req;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   // Pipeline stage side issues requests.
   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   // Memory side answers them.
   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-cycle counter that flags when the bus has hung too long
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   // Clear wins over count so every fresh wait starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage with stall/timeout control and MEM/WB register
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int AW      = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EXMEM_M2R,
   input  logic              EXMEM_RegWr,
   input  logic [DATA_W-1:0] EXMEM_aluout,
   input  logic [DATA_W-1:0] MEMData,
   input  logic [RD_W-1:0]   EXMEM_Rd,
   input  logic              MemWr,
   input  logic              MemR,
   mem_wb_stage_if.master    mem,
   output logic              mem_stall,
   output logic              MEMWB_RegWr,
   output logic [RD_W-1:0]   MEMWB_Rd,
   output logic [DATA_W-1:0] MEMWB_WrData,
   output logic              mem_err
);

   mem_state_e state, state_nxt;
   memwb_t     wb_q, wb_nxt, wb_pass, wb_done;
   logic       access, misaligned;
   logic       req, stall, err_set;
   logic       ctr_clr, ctr_en, ctr_expired;

   assign access     = MemR | MemWr;
   assign misaligned = access & ~word_aligned(EXMEM_aluout[1:0]);

   assign wb_pass = '{regwr: EXMEM_RegWr, rd: EXMEM_Rd, wrdata: EXMEM_aluout};
   assign wb_done = '{regwr: EXMEM_RegWr, rd: EXMEM_Rd,
                      wrdata: (EXMEM_M2R ? mem.mem_rdata : EXMEM_aluout)};

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ctr_clr),
      .en      (ctr_en),
      .expired (ctr_expired)
   );

   // Next state, request/stall strobes and the value MEM/WB captures this cycle.
   always_comb begin
      state_nxt = state;
      wb_nxt    = MEMWB_BUBBLE;
      req       = 1'b0;
      stall     = 1'b0;
      err_set   = 1'b0;
      ctr_clr   = 1'b0;
      ctr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!access) begin
               wb_nxt = wb_pass;
            end else if (misaligned) begin
               err_set = 1'b1;
            end else begin
               req = 1'b1;
               if (mem.mem_ack) begin
                  wb_nxt = wb_done;
               end else begin
                  state_nxt = ST_WAIT;
                  stall     = 1'b1;
                  ctr_clr   = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!access) begin
               // EX/MEM is frozen while waiting, so this only guards odd upstream behaviour.
               state_nxt = ST_IDLE;
            end else if (ctr_expired) begin
               // Hung bus: drop the request, retire as a bubble and let the pipe move.
               err_set   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               req = 1'b1;
               if (mem.mem_ack) begin
                  wb_nxt    = wb_done;
                  state_nxt = ST_IDLE;
               end else begin
                  stall  = 1'b1;
                  ctr_en = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // MEM/WB pipeline register and sticky fault flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q    <= MEMWB_BUBBLE;
         mem_err <= 1'b0;
      end else begin
         wb_q <= wb_nxt;
         if (err_set) begin
            mem_err <= 1'b1;
         end
      end
   end

   // Strobes are masked by reset so an aborted access releases the bus at once.
   assign mem.mem_req   = req & rst_n;
   assign mem.mem_we    = req & MemWr & rst_n;
   assign mem.mem_addr  = EXMEM_aluout[AW+1:2];
   assign mem.mem_wdata = MEMData;
   assign mem_stall     = stall & rst_n;

   assign MEMWB_RegWr  = wb_q.regwr;
   assign MEMWB_Rd     = wb_q.rd;
   assign MEMWB_WrData = wb_q.wrdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

   localparam int TIMEOUT = 16;
   localparam int AW      = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        EXMEM_M2R, EXMEM_RegWr, MemWr, MemR;
   logic [31:0] EXMEM_aluout, MEMData;
   logic [4:0]  EXMEM_Rd;
   logic        mem_stall, MEMWB_RegWr, mem_err;
   logic [4:0]  MEMWB_Rd;
   logic [31:0] MEMWB_WrData;

   always #5 clk = ~clk;

   mem_wb_stage_if #(.AW(AW)) mif ();

   mem_wb_stage #(
      .TIMEOUT (TIMEOUT),
      .AW      (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .EXMEM_M2R    (EXMEM_M2R),
      .EXMEM_RegWr  (EXMEM_RegWr),
      .EXMEM_aluout (EXMEM_aluout),
      .MEMData      (MEMData),
      .EXMEM_Rd     (EXMEM_Rd),
      .MemWr        (MemWr),
      .MemR         (MemR),
      .mem          (mif),
      .mem_stall    (mem_stall),
      .MEMWB_RegWr  (MEMWB_RegWr),
      .MEMWB_Rd     (MEMWB_Rd),
      .MEMWB_WrData (MEMWB_WrData),
      .mem_err      (mem_err)
   );

   typedef struct {
      bit          bubble;
      bit          regwr;
      logic [4:0]  rd;
      logic [31:0] data;
      bit          err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t drv_e;
   int   total = 0;
   int   bad   = 0;
   bit   model_err = 1'b0;

   int          r_kind, r_sel, r_lat;
   bit          r_ld, r_st;
   logic [31:0] r_alu;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: every edge that has a queued expectation is compared after it settles.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("wb_regwr", 64'(MEMWB_RegWr), 64'(mon_e.regwr));
         if (!mon_e.bubble) begin
            chk("wb_rd", 64'(MEMWB_Rd), 64'(mon_e.rd));
            chk("wb_data", 64'(MEMWB_WrData), 64'(mon_e.data));
         end
         chk("mem_err", 64'(mem_err), 64'(mon_e.err));
      end
   end

   // One instruction held in EX/MEM until the stage lets it go.
   // lat >= 0: ack arrives that many cycles after the first request; lat < 0: never.
   task automatic run_instr(input bit ld, input bit st, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [4:0] rd, input bit rw,
                            input bit m2r, input int lat, input logic [31:0] rdata);
      bit acc, mis, ack_now, exp_req, exp_stall;
      int ncyc;
      acc = ld | st;
      mis = acc && ((alu % 4) != 0);
      if (!acc || mis)  ncyc = 1;
      else if (lat < 0) ncyc = TIMEOUT + 1;
      else              ncyc = lat + 1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         MemR = ld; MemWr = st; EXMEM_aluout = alu; MEMData = wd;
         EXMEM_Rd = rd; EXMEM_RegWr = rw; EXMEM_M2R = m2r;
         if (acc && !mis)
            ack_now = (lat >= 0) ? (c == lat) : (c == TIMEOUT && $urandom_range(0, 1) == 1);
         else
            ack_now = ($urandom_range(0, 1) == 1);
         mif.mem_ack   = ack_now;
         mif.mem_rdata = (acc && !mis && lat >= 0 && c == lat) ? rdata : $urandom();
         exp_req   = acc && !mis && (lat >= 0 || c < TIMEOUT);
         exp_stall = exp_req && !(lat >= 0 && c == lat);
         #2;
         chk("mem_req", 64'(mif.mem_req), 64'(exp_req));
         chk("mem_stall", 64'(mem_stall), 64'(exp_stall));
         chk("mem_we", 64'(mif.mem_we), 64'(exp_req && st));
         if (exp_req) begin
            chk("mem_addr", 64'(mif.mem_addr), 64'((alu / 4) % (1 << AW)));
            chk("mem_wdata", 64'(mif.mem_wdata), 64'(wd));
         end
         drv_e.bubble = 1'b1; drv_e.regwr = 1'b0; drv_e.rd = '0; drv_e.data = '0;
         if (!acc) begin
            drv_e.bubble = 1'b0; drv_e.regwr = rw; drv_e.rd = rd; drv_e.data = alu;
         end else if (mis) begin
            model_err = 1'b1;
         end else if (lat >= 0 && c == lat) begin
            drv_e.bubble = 1'b0; drv_e.regwr = rw; drv_e.rd = rd;
            drv_e.data = m2r ? rdata : alu;
         end else if (lat < 0 && c == TIMEOUT) begin
            model_err = 1'b1;
         end
         drv_e.err = model_err;
         exp_q.push_back(drv_e);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      MemR = 0; MemWr = 0; EXMEM_aluout = '0; MEMData = '0; EXMEM_Rd = '0;
      EXMEM_RegWr = 0; EXMEM_M2R = 0; mif.mem_ack = 0; mif.mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_regwr", 64'(MEMWB_RegWr), 64'd0);
      chk("rst_rd", 64'(MEMWB_Rd), 64'd0);
      chk("rst_data", 64'(MEMWB_WrData), 64'd0);
      chk("rst_err", 64'(mem_err), 64'd0);
      chk("rst_req", 64'(mif.mem_req), 64'd0);
      chk("rst_stall", 64'(mem_stall), 64'd0);
      rst_n = 1'b1;

      // Directed cases.
      run_instr(0, 0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 32'h0);
      run_instr(1, 0, 32'h40, 32'h0, 5'd7, 1, 1, 0, 32'hDEADBEEF);
      run_instr(0, 1, 32'h80, 32'hCAFEF00D, 5'd0, 0, 0, 3, 32'h0);
      run_instr(1, 0, 32'h42, 32'h0, 5'd3, 1, 1, 0, 32'h0);

      // Reset in the middle of a load that would need five cycles.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         MemR = 1; MemWr = 0; EXMEM_aluout = 32'h100; EXMEM_Rd = 5'd4;
         EXMEM_RegWr = 1; EXMEM_M2R = 1; mif.mem_ack = 0;
         #2;
         chk("wait_req", 64'(mif.mem_req), 64'd1);
         chk("wait_stall", 64'(mem_stall), 64'd1);
         drv_e.bubble = 1'b1; drv_e.regwr = 1'b0; drv_e.rd = '0; drv_e.data = '0;
         drv_e.err = model_err;
         exp_q.push_back(drv_e);
      end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_regwr", 64'(MEMWB_RegWr), 64'd0);
      chk("abort_rd", 64'(MEMWB_Rd), 64'd0);
      chk("abort_data", 64'(MEMWB_WrData), 64'd0);
      chk("abort_err", 64'(mem_err), 64'd0);
      chk("abort_req", 64'(mif.mem_req), 64'd0);
      chk("abort_stall", 64'(mem_stall), 64'd0);
      exp_q.delete();
      model_err = 1'b0;
      @(negedge clk);
      MemR = 0;
      rst_n = 1'b1;
      run_instr(0, 0, 32'h5555AAAA, 32'h0, 5'd9, 1, 0, 0, 32'h0);
      run_instr(1, 0, 32'h104, 32'h0, 5'd4, 1, 1, 0, 32'h13579BDF);

      // Hung bus, late ack afterwards, then the longest wait that still completes.
      run_instr(1, 0, 32'h44, 32'h0, 5'd11, 1, 1, -1, 32'h0);
      run_instr(0, 0, 32'h77, 32'h0, 5'd12, 1, 0, 0, 32'h0);
      run_instr(1, 0, 32'h3FC, 32'h0, 5'd13, 1, 1, TIMEOUT - 1, 32'h0BADF00D);
      run_instr(0, 1, 32'hFFC, 32'h1, 5'd14, 1, 0, 1, 32'h0);

      // Randomized mix.
      for (int i = 0; i < 150; i++) begin
         r_kind = $urandom_range(0, 9);
         r_ld   = (r_kind <= 3);
         r_st   = (r_kind >= 4 && r_kind <= 6);
         r_alu  = $urandom();
         if ($urandom_range(0, 7) != 0) r_alu = r_alu & 32'hFFFF_FFFC;
         r_sel = $urandom_range(0, 19);
         if (r_sel == 0)      r_lat = -1;
         else if (r_sel == 1) r_lat = TIMEOUT - 1;
         else                 r_lat = $urandom_range(0, 4);
         run_instr(r_ld, r_st, r_alu, $urandom(), 5'($urandom()), 1'($urandom()),
                   1'($urandom()), r_lat, $urandom());
      end

      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage pipeline, directly downstream of the EX/MEM register. Performs load/store against a variable-latency data-memory port, freezes the upstream pipeline while an access is outstanding, and registers the resolved write-back value, destination and RegWr for the register file. Bus-hang timeout and misalignment detection retire faulting instructions as bubbles and raise a sticky error.

## Interface
- `TIMEOUT`, 16: max cycles spent in WAIT before abort (≥2)
- `AW`, 10: data-memory word-address width

- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `EXMEM_M2R` in 1: write-back selects memory data (1) or ALU result (0)
- `EXMEM_RegWr` in 1: instruction writes register file
- `EXMEM_aluout` in 32: ALU result / byte address
- `MEMData` in 32: store data
- `EXMEM_Rd` in 5: destination register
- `MemWr`, `MemR` in 1 each: store / load request (never both)
- `mem_req` out 1: memory request
- `mem_we` out 1: write strobe, valid with `mem_req`
- `mem_addr` out AW: word address `EXMEM_aluout[AW+1:2]`
- `mem_wdata` out 32: `MEMData`
- `mem_rdata` in 32: read data, valid with `mem_ack`
- `mem_ack` in 1: access complete
- `mem_stall` out 1: freeze PC/IFID/IDEX/EXMEM this cycle
- `MEMWB_RegWr` out 1, `MEMWB_Rd` out 5, `MEMWB_WrData` out 32: write-back bundle
- `mem_err` out 1: sticky fault flag, cleared only by reset

## Operation
- `access = MemR | MemWr`; `misaligned = access & (EXMEM_aluout[1:0] != 0)`.
- FSM states IDLE, WAIT. Reset → IDLE.
- IDLE, no access: no request; MEM/WB loads `RegWr=EXMEM_RegWr`, `Rd=EXMEM_Rd`, `WrData=EXMEM_aluout`.
- IDLE, misaligned: no request, `mem_err`←1, MEM/WB loads bubble (`RegWr=0`), stay IDLE, no stall.
- IDLE, aligned access: `mem_req=1` combinationally. `mem_ack` same cycle → complete (below), stay IDLE, no stall. Otherwise → WAIT, `mem_stall=1`, MEM/WB loads bubble.
- WAIT: `mem_req` held, address/data/we stable (EX/MEM frozen by stall). Each cycle without ack: bubble, stall=1, counter+1.
- Complete: MEM/WB loads `RegWr=EXMEM_RegWr`, `Rd`, `WrData = EXMEM_M2R ? mem_rdata : EXMEM_aluout`; `mem_stall=0` that cycle; WAIT → IDLE.
- Timeout: counter reaches TIMEOUT-1 in WAIT with no ack → `mem_req` dropped, `mem_err`←1, bubble, stall=0, → IDLE; instruction retired without effect. Late ack arriving in IDLE with no request is ignored.
- Counter cleared on every entry to WAIT; width `$clog2(TIMEOUT)`.

## Timing
- Reset values: state IDLE, counter 0, `MEMWB_RegWr=0`, `MEMWB_Rd=0`, `MEMWB_WrData=0`, `mem_err=0`. `mem_req`, `mem_we`, `mem_stall` are 0 whenever `access=0`, including during reset.
- Zero-wait memory: 1-cycle latency EX/MEM → MEM/WB, no stall.
- N-cycle ack (N≥1 cycles after first request): stall asserted for N cycles, deasserted in the ack cycle; result in MEM/WB at the following edge.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_stall` are combinational from inputs and state; all MEM/WB outputs registered.
- Reset asserted mid-WAIT: immediate abort, outputs to reset values, no `mem_err`.

## Structure
- Shared pipeline package: state encoding (IDLE=0, WAIT=1) and the MEM/WB bundle field widths (5-bit Rd, 32-bit data).
- One natural sub-module: `mem_timeout_ctr` (clear/enable/expire counter parameterised by TIMEOUT); the FSM and MEM/WB register stay in the top.

## Test plan
- ALU op, `EXMEM_aluout=0x1234`, `Rd=5`, RegWr=1 → next edge `MEMWB_WrData=0x1234`, `Rd=5`, RegWr=1, no request.
- Load addr `0x40`, ack same cycle with `rdata=0xDEADBEEF`, M2R=1 → `mem_addr=0x10`, no stall, `MEMWB_WrData=0xDEADBEEF`.
- Store addr `0x80`, data `0xCAFEF00D`, ack after 3 cycles → `mem_we=1` and stable for 4 cycles, stall high 3 cycles, bubbles in MEM/WB, `MEMWB_RegWr=0` throughout.
- Load with no ack, TIMEOUT=16 → `mem_req` drops after 16 cycles, `mem_err=1`, stall drops, bubble retired; later ack ignored.
- Load addr `0x42` → no request, `mem_err=1`, bubble, no stall.
- `rst_n` low during WAIT of a 5-cycle load → outputs reset immediately, `mem_err=0`, IDLE after release.
